pipelined_adder_sub: RTL and testbench

- Parametrised successor to the 32-bit ripple-carry adder: a WIDTH-bit adder/subtractor whose carry chain is split into STAGES registered segments.
- Uses a valid/ready stream handshake on both input and output.
- Sits in the datapath wherever a wide add/sub must close timing at full clock rate; accepts one operation per cycle when not back-pressured.

---
 rtl/pipelined_adder_sub.sv | 105 ++++++++++
 tb/tb_pipelined_adder_sub.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_sub.sv
// rtl/pipelined_adder_sub.sv - WIDTH-bit add/sub with the carry chain split into STAGES registered segments
// Valid/ready stream on both sides; one operation per cycle when not back-pressured.
module pipelined_adder_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Rank k holds an operation whose chunks below k are resolved into s_q and
  // whose carry into chunk k is c_q; the full operands travel with it.
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];

  logic [CHUNK:0]   chunk_sum [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];

  logic             out_valid_q;
  logic [WIDTH-1:0] s_out_q;
  logic             cout_q;
  logic             ovf_q;
  logic             ovf_d;
  logic             advance;

  assign advance  = out_ready || !out_valid_q;
  assign in_ready = advance;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      chunk_sum[k] = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
                   + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, c_q[k]};
      s_d[k] = s_q[k];
      s_d[k][k*CHUNK +: CHUNK] = chunk_sum[k][CHUNK-1:0];
      c_d[k] = chunk_sum[k][CHUNK];
    end
    ovf_d = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
            (s_d[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      s_out_q     <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      v_q[0] <= in_valid;
      if (in_valid) begin
        a_q[0] <= A;
        b_q[0] <= sub ? ~B : B;
        s_q[0] <= '0;
        c_q[0] <= sub ? ~cin : cin;
      end
      // Bubbles shift their valid bit only, so data registers keep the last real op.
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
          s_q[k] <= s_d[k-1];
          c_q[k] <= c_d[k-1];
        end
      end
      out_valid_q <= v_q[LAST];
      if (v_q[LAST]) begin
        s_out_q <= s_d[LAST];
        cout_q  <= c_d[LAST];
        ovf_q   <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign S         = s_out_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// tb/tb_pipelined_adder_sub.sv - scoreboard bench for pipelined_adder_sub at STAGES = 4, 1 and 32
// One instance is exercised at a time; every instance's monitor runs continuously.
module tb_pipelined_adder_sub;

  localparam int NI = 3;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        of;
    int          acc;
    bit          lat;
    int          inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv   [NI];
  logic        ir   [NI];
  logic [31:0] a_s  [NI];
  logic [31:0] b_s  [NI];
  logic        ci_s [NI];
  logic        sb_s [NI];
  logic        ov   [NI];
  logic        ordy [NI];
  logic [31:0] s_o  [NI];
  logic        co   [NI];
  logic        of   [NI];

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   cur = 0;
  int   xfer_cnt = 0;
  bit   started = 1'b0;
  bit   lat_chk = 1'b0;
  bit   done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int stages_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 32);
  endfunction

  task automatic chk(input int inst, input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL inst%0d(stages=%0d) %s: got %0h expected %0h at cycle %0d",
               inst, stages_of(inst), nm, act, expv, cyc);
    end
  endtask

  task automatic fail(input int inst, input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL inst%0d %s: bound expired at cycle %0d", inst, nm, cyc);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic s);
    exp_t   r;
    longint ua, ub, sa, sbv, ci, t, st;
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ci  = longint'({63'd0, c});
    if (s) begin
      t    = ua - ub - ci;
      st   = sa - sbv - ci;
      r.co = (t >= 0);
    end else begin
      t    = ua + ub + ci;
      st   = sa + sbv + ci;
      r.co = t[32];
    end
    r.s    = t[31:0];
    r.of   = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    r.acc  = 0;
    r.lat  = 1'b0;
    r.inst = 0;
    return r;
  endfunction

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : gi
      localparam int STG = (g == 0) ? 4 : ((g == 1) ? 1 : 32);

      pipelined_adder_sub #(.WIDTH(32), .STAGES(STG)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[g]), .in_ready(ir[g]),
        .A(a_s[g]), .B(b_s[g]), .cin(ci_s[g]), .sub(sb_s[g]),
        .out_valid(ov[g]), .out_ready(ordy[g]),
        .S(s_o[g]), .cout(co[g]), .ovf(of[g])
      );

      bit          p_hold = 1'b0;
      logic [31:0] p_s;
      logic        p_co, p_of;
      exp_t        e;

      always @(negedge clk) begin
        if (started) begin
          chk(g, "in_ready", ir[g], ordy[g] || !ov[g]);
          if (p_hold) begin
            chk(g, "hold_valid", ov[g], 1);
            chk(g, "hold_S", s_o[g], p_s);
            chk(g, "hold_cout", co[g], p_co);
            chk(g, "hold_ovf", of[g], p_of);
          end
          if (rst_n && ov[g] && ordy[g]) begin
            if (q.size() == 0 || q[0].inst != g) begin
              chk(g, "spurious_out_valid", ov[g], 0);
            end else begin
              e = q.pop_front();
              chk(g, "S", s_o[g], e.s);
              chk(g, "cout", co[g], e.co);
              chk(g, "ovf", of[g], e.of);
              if (e.lat) chk(g, "latency", cyc - e.acc, STG);
              xfer_cnt++;
            end
          end
          p_hold = rst_n && ov[g] && !ordy[g];
          p_s    = s_o[g];
          p_co   = co[g];
          p_of   = of[g];
        end
      end
    end
  endgenerate

  task automatic scramble();
    a_s[cur]  = $urandom;
    b_s[cur]  = $urandom;
    ci_s[cur] = 1'($urandom_range(0, 1));
    sb_s[cur] = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    exp_t e;
    int   n = 0;
    forever begin
      iv[cur] = 1'b1; a_s[cur] = a; b_s[cur] = b; ci_s[cur] = c; sb_s[cur] = s;
      @(negedge clk);
      if (ir[cur]) begin
        e      = model(a, b, c, s);
        e.acc  = cyc + 1;
        e.lat  = lat_chk;
        e.inst = cur;
        q.push_back(e);
        break;
      end
      // Not accepted at the coming edge, so these values must be ignored.
      scramble();
      n++;
      if (n > 200) begin
        fail(cur, "accept_wait");
        break;
      end
      @(posedge clk); #1;
    end
    if (lat_chk) chk(cur, "stall_cycles_at_full_rate", n, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    iv[cur] = 1'b0;
    repeat (n) begin
      scramble();
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int k = 0;
    iv[cur] = 1'b0;
    while (q.size() != 0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (q.size() != 0) begin
      fail(cur, "drain");
      q.delete();
    end
    idle(3);
  endtask

  task automatic send_rand();
    logic [31:0] a, b;
    case ($urandom_range(0, 5))
      0:       a = 32'hFFFF_FFFF;
      1:       a = 32'h7FFF_FFFF;
      2:       a = 32'h8000_0000;
      default: a = $urandom;
    endcase
    b = ($urandom_range(0, 4) == 0) ? 32'h0000_0001 : $urandom;
    send(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; a_s[i] = '0; b_s[i] = '0; ci_s[i] = 1'b0; sb_s[i] = 1'b0;
    end
    for (int i = 0; i < NI; i++) begin
      int base, k;
      cur     = i;
      lat_chk = 1'b1;

      rst_n = 1'b0;
      iv[cur] = 1'b1; a_s[cur] = 32'h1234_5678; b_s[cur] = 32'h0000_0001;
      @(posedge clk); #1;
      started = 1'b1;
      repeat (2) begin
        @(negedge clk);
        chk(cur, "rst_out_valid", ov[cur], 0);
        chk(cur, "rst_S", s_o[cur], 0);
        chk(cur, "rst_cout", co[cur], 0);
        chk(cur, "rst_ovf", of[cur], 0);
        chk(cur, "rst_in_ready", ir[cur], 1);
        @(posedge clk); #1;
      end
      rst_n = 1'b1;

      send(32'd1, 32'd0, 1'b0, 1'b0);
      send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
      send(32'd12, 32'd4, 1'b0, 1'b1);
      send(32'd4, 32'd12, 1'b0, 1'b1);
      send(32'd12, 32'd4, 1'b1, 1'b1);
      send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
      send(32'd5, 32'd3, 1'b0, 1'b0);
      drain();

      lat_chk = 1'b0;
      base = xfer_cnt;
      fork
        begin
          for (int j = 0; j < 8; j++) send(32'(j), 32'd4, 1'b0, 1'b0);
          iv[cur] = 1'b0;
        end
        begin
          k = 0;
          while (xfer_cnt < base + 2 && k < 200) begin
            @(posedge clk); #1;
            k++;
          end
          if (k >= 200) fail(cur, "second_result_wait");
          ordy[cur] = 1'b0;
          repeat (3) @(posedge clk);
          #1;
          ordy[cur] = 1'b1;
        end
      join
      drain();

      done = 1'b0;
      fork
        begin
          for (int j = 0; j < 120; j++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            send_rand();
          end
          iv[cur] = 1'b0;
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk); #1;
            ordy[cur] = ($urandom_range(0, 3) != 0);
          end
          ordy[cur] = 1'b1;
        end
      join
      drain();

      lat_chk = 1'b1;
      for (int j = 0; j < 40; j++) send_rand();
      drain();

      lat_chk = 1'b0;
      for (int j = 0; j < 3; j++) send_rand();
      iv[cur] = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      q.delete();
      repeat (6) begin
        @(negedge clk);
        chk(cur, "post_reset_valid", ov[cur], 0);
        @(posedge clk); #1;
      end
      lat_chk = 1'b1;
      send(32'd12, 32'd4, 1'b0, 1'b0);
      drain();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
